// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bus bundle for fifo_rd_ctrl: the RAM read port and the
// valid/ready output stream. The controller is the master; the RAM and
// the downstream consumer together form the slave side.
interface fifo_rd_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output mem_rd_en, mem_rd_addr, out_data, out_valid,
    input  mem_rd_data, out_ready
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr, out_data, out_valid,
    output mem_rd_data, out_ready
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Destination-domain read controller for the async FIFO. Fetches words
// from the dual-port RAM (one cycle read latency) into a 2-entry output
// buffer and exports the binary read pointer for the reverse crossing.
module fifo_rd_ctrl #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int AE_THRESH = 2
) (
  input  logic              dest_clk,
  input  logic              rst_n,
  input  logic [ADDR_W:0]   wr_ptr_sync,
  input  logic              flush,
  output logic [ADDR_W:0]   rd_ptr,
  output logic [ADDR_W:0]   mem_level,
  output logic              almost_empty,
  fifo_rd_ctrl_if.master    bus
);

  localparam logic [ADDR_W:0] AE_LVL = (ADDR_W+1)'(AE_THRESH);

  // Stage p1: RAM read in flight; stage p2: output buffer (head + tail)
  logic              vld_p1;
  logic [1:0]        cnt_p2;
  logic [DATA_W-1:0] head_p2;
  logic [DATA_W-1:0] tail_p2;
  logic              out_vld_p2;

  logic              avail;
  logic              pop;
  logic [2:0]        occ;
  logic [2:0]        occ_after_pop;
  logic              rd_issue;
  logic [1:0]        cnt_nxt;
  logic [DATA_W-1:0] head_nxt;
  logic [DATA_W-1:0] tail_nxt;

  // Occupancy counts both buffered words and the read still in flight,
  // so a word issued now always has a buffer slot when it returns.
  assign mem_level     = wr_ptr_sync - rd_ptr;
  assign avail         = (mem_level != '0);
  assign almost_empty  = (mem_level <= AE_LVL);
  assign pop           = out_vld_p2 & bus.out_ready;
  assign occ           = {1'b0, cnt_p2} + {2'b00, vld_p1};
  assign occ_after_pop = occ - {2'b00, pop};
  assign rd_issue      = avail & ~flush & (occ_after_pop < 3'd2);

  assign bus.mem_rd_en   = rd_issue;
  assign bus.mem_rd_addr = rd_ptr[ADDR_W-1:0];
  assign bus.out_data    = head_p2;
  assign bus.out_valid   = out_vld_p2;

  // Next buffer contents from pop/return; flush discards everything
  always_comb begin
    cnt_nxt  = cnt_p2;
    head_nxt = head_p2;
    tail_nxt = tail_p2;
    if (flush) begin
      cnt_nxt = 2'd0;
    end else begin
      case ({pop, vld_p1})
        2'b11: begin
          if (cnt_p2 == 2'd2) begin
            head_nxt = tail_p2;
            tail_nxt = bus.mem_rd_data;
          end else begin
            head_nxt = bus.mem_rd_data;
          end
        end
        2'b10: begin
          head_nxt = tail_p2;
          cnt_nxt  = cnt_p2 - 2'd1;
        end
        2'b01: begin
          if (cnt_p2 == 2'd0) head_nxt = bus.mem_rd_data;
          else                tail_nxt = bus.mem_rd_data;
          cnt_nxt = cnt_p2 + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Pointer, in-flight flag, buffer count and registered head word
  always_ff @(posedge dest_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      vld_p1     <= 1'b0;
      cnt_p2     <= 2'd0;
      out_vld_p2 <= 1'b0;
      head_p2    <= '0;
    end else begin
      if (flush)         rd_ptr <= wr_ptr_sync;
      else if (rd_issue) rd_ptr <= rd_ptr + 1'b1;
      vld_p1     <= rd_issue;
      cnt_p2     <= cnt_nxt;
      out_vld_p2 <= (cnt_nxt != 2'd0);
      head_p2    <= head_nxt;
    end
  end

  // Second buffer entry is pure data, qualified by cnt_p2
  always_ff @(posedge dest_clk) begin
    tail_p2 <= tail_nxt;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
Read-side controller for the asynchronous FIFO. It runs entirely in the destination clock domain and consumes the binary write pointer after it has been carried across by the gray-code double-flop transmitter path. It sequences reads from the synchronous dual-port RAM and presents words through a 2-entry valid/ready output buffer at full throughput. It also produces the binary read pointer that the reverse transmitter carries back to the write domain for full detection.

Parameters:
ADDR_W, 4, RAM address width; depth = 2^ADDR_W; pointers are ADDR_W+1 bits (extra wrap bit)
DATA_W, 8, data word width
AE_THRESH, 2, almost_empty asserted when mem_level <= AE_THRESH

Ports:
dest_clk  in  1  destination-domain clock; all state on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
wr_ptr_sync  in  ADDR_W+1  binary write pointer, already synchronized to dest_clk
flush  in  1  synchronous discard of all unread data
mem_rd_en  out  1  RAM read strobe (combinational)
mem_rd_addr  out  ADDR_W  RAM read address = rd_ptr[ADDR_W-1:0]
mem_rd_data  in  DATA_W  RAM read data, valid the cycle after mem_rd_en
out_data  out  DATA_W  head word of output buffer
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts when out_valid & out_ready
rd_ptr  out  ADDR_W+1  binary read pointer, count of words fetched from RAM, mod 2^(ADDR_W+1)
mem_level  out  ADDR_W+1  words in RAM not yet fetched = wr_ptr_sync - rd_ptr (mod 2^(ADDR_W+1))
almost_empty  out  1  mem_level <= AE_THRESH (combinational)

Behaviour:
- Reset (rst_n low, asynchronous): rd_ptr=0, inflight=0, buffer count=0, out_valid=0, out_data=0. Combinational outputs follow: mem_rd_en=0, mem_level=wr_ptr_sync.
- avail = (mem_level != 0). pop = out_valid & out_ready. occ = buffered words (0..2) + inflight (0..1).
- Issue rule: mem_rd_en = avail & ~flush & ((occ - pop) < 2). On issue, rd_ptr increments by 1 at the clock edge and inflight is set for the next cycle.
- Return: when inflight=1, mem_rd_data is written into the buffer tail at that edge. The buffer is 2 entries, FIFO order, and never overflows because of the issue rule.
- Latency: a word becomes readable in cycle N (mem_rd_en=1 in N), is captured at the end of N+1, and out_valid=1 in N+2.
- Throughput: steady state is 1 word/cycle with out_ready=1 and no bubbles.
- Pop and return in the same cycle: the head is removed, the new word is appended, and the count is unchanged.
- Pop while the buffer holds 2 words: the second entry moves to the head.
- Output semantics: out_data/out_valid are registered. out_data must be held stable while out_valid & ~out_ready.
- Wrap: pointer arithmetic is modulo 2^(ADDR_W+1). mem_rd_addr wraps from 2^ADDR_W-1 to 0.
- Never read past the write pointer: no mem_rd_en when mem_level=0.
- wr_ptr_sync may jump by more than 1 per cycle (synchronizer sampling). It is treated only as a count.
- Flush (synchronous): at the edge, rd_ptr <= wr_ptr_sync, the buffer is emptied, and out_valid=0 next cycle. A returning in-flight word is dropped and inflight clears. mem_rd_en=0 during the flush cycle. Flush has priority over pop and return.
- Reset mid-stream: all state clears immediately. Buffered and in-flight data are lost. The write domain observes rd_ptr=0 via the reverse path.

Test Plan:
1. Reset: hold rst_n=0 with wr_ptr_sync=0 -> out_valid=0, rd_ptr=0, mem_rd_en=0, mem_level=0, almost_empty=1.
2. Single word: wr_ptr_sync 0->1 at cycle N, RAM word 0xA5 -> mem_rd_en=1, addr 0 in N; out_valid=1, out_data=0xA5 in N+2; rd_ptr=1, mem_level=0.
3. Streaming: wr_ptr_sync=8, out_ready=1, RAM[i]=i+0x10 -> 8 consecutive pops 0x10..0x17 with no bubble; rd_ptr=8.
4. Backpressure: wr_ptr_sync=6, out_ready=0 -> reads stop at rd_ptr=2, out_data held at 0x10. Then release -> remaining words in order, rd_ptr=6.
5. Wrap: preset rd_ptr=30 via flush with wr_ptr_sync=30, then wr_ptr_sync=2 -> mem_level=4; addresses 14,15,0,1; rd_ptr ends at 2.
6. Flush mid-stream: wr_ptr_sync=8, 2 words buffered plus 1 in flight, flush=1 -> out_valid=0 next cycle, rd_ptr=8, in-flight word not presented.
